// File: rtl/piso_serializer_pkg.sv
// Shared types and width helper for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// Bit-period divider: tick on the last cycle of a bit, first on its opening cycle.
// Counter advances only while enabled; synchronous clear wins over enable.
module bit_timer
    import piso_serializer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic first
);

    localparam int            CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    assign tick  = (div_cnt_q == LAST);
    assign first = (div_cnt_q == '0);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Word-to-bit serializer, first bit one cycle after accept; in_ready low while a word is in flight.
// PISO_SERIALIZER_PRELOAD_EN adds a one-word holding buffer so consecutive words run gapless.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int DIV        = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  bit_strobe,
    output logic                  busy,
    output logic                  done
);

    localparam int            BW       = cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    ser_out_q, ser_out_d;
    logic                    done_q, done_d;
    logic                    timer_en, timer_clr;
    logic                    tick, first;
    logic                    accept;

`ifdef PISO_SERIALIZER_PRELOAD_EN
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;

    assign in_ready = !rst && !hold_full_q;
`else
    assign in_ready = !rst && (state_q == IDLE);
`endif

    assign accept     = in_valid && in_ready;
    assign ser_out    = ser_out_q;
    assign ser_valid  = (state_q == SHIFT);
    assign busy       = (state_q == SHIFT);
    assign bit_strobe = (state_q == SHIFT) && first;
    assign done       = done_q;

    assign shifted = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[DATA_WIDTH-1:1]};

    bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (timer_en),
        .clr   (timer_clr),
        .tick  (tick),
        .first (first)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        timer_en  = 1'b0;
        timer_clr = 1'b0;
`ifdef PISO_SERIALIZER_PRELOAD_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = in_data;
                    bit_cnt_d = '0;
                    timer_clr = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                timer_en = 1'b1;
`ifdef PISO_SERIALIZER_PRELOAD_EN
                if (accept) begin
                    hold_d      = in_data;
                    hold_full_d = 1'b1;
                end
`endif
                if (tick) begin
                    shift_d = shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
`ifdef PISO_SERIALIZER_PRELOAD_EN
                        // Chain straight into the next word; the timer has already wrapped to 0.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            state_d     = SHIFT;
                            hold_full_d = accept;
                        end else if (accept) begin
                            shift_d     = in_data;
                            state_d     = SHIFT;
                            hold_full_d = 1'b0;
                        end
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ser_out_d = IDLE_LEVEL;
        if (state_d == SHIFT) begin
            ser_out_d = MSB_FIRST ? shift_d[DATA_WIDTH-1] : shift_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ser_out_q <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ser_out_q <= ser_out_d;
            done_q    <= done_d;
        end
    end

`ifdef PISO_SERIALIZER_PRELOAD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first DIV=1 idle-low, LSB-first DIV=3 idle-high).
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_SERIALIZER_PRELOAD_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      in_valid;
    logic [1:0][7:0] in_data;
    logic [1:0]      in_ready, ser_out, ser_valid, bit_strobe, busy, done;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .DIV(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
        .bit_strobe(bit_strobe[0]), .busy(busy[0]), .done(done[0]));

    piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .DIV(3), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
        .bit_strobe(bit_strobe[1]), .busy(busy[1]), .done(done[1]));

    int checks = 0;
    int errors = 0;

    // Reference model: each in-flight word is tracked as (word, cycle index k within its W*DIV cycles).
    bit         m_active [2];
    logic [7:0] m_word   [2];
    int         m_k      [2];
    bit         m_hf     [2];
    logic [7:0] m_hold   [2];
    bit         m_done   [2];

    function automatic int pdiv(input int p);
        return (p == 0) ? 1 : 3;
    endfunction

    function automatic bit pmsb(input int p);
        return (p == 0);
    endfunction

    function automatic logic pidle(input int p);
        return (p == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_ready(input int p, input logic r);
        return !r && (PRE ? !m_hf[p] : !m_active[p]);
    endfunction

    function automatic logic exp_ser(input int p);
        int b;
        if (!m_active[p]) return pidle(p);
        b = m_k[p] / pdiv(p);
        return pmsb(p) ? m_word[p][W-1-b] : m_word[p][b];
    endfunction

    task automatic model_edge(input int p, input logic v, input logic [7:0] d, input logic r);
        bit acc;
        int last;
        acc  = v && exp_ready(p, r);
        last = W * pdiv(p) - 1;
        if (r) begin
            m_active[p] = 1'b0; m_k[p] = 0; m_hf[p] = 1'b0; m_done[p] = 1'b0;
            return;
        end
        m_done[p] = 1'b0;
        if (!m_active[p]) begin
            if (acc) begin
                m_active[p] = 1'b1; m_word[p] = d; m_k[p] = 0;
            end
        end else if (m_k[p] != last) begin
            m_k[p]++;
            if (acc) begin
                m_hold[p] = d; m_hf[p] = 1'b1;
            end
        end else begin
            m_done[p] = 1'b1;
            m_k[p]    = 0;
            if (m_hf[p]) begin
                m_word[p] = m_hold[p];
                m_hf[p]   = acc;
                if (acc) m_hold[p] = d;
            end else if (acc) begin
                m_word[p] = d;
            end else begin
                m_active[p] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive inputs, check in_ready, clock once, then compare every output against the model.
    task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                        input logic r);
        rst = r;
        in_valid[0] = v0; in_data[0] = d0;
        in_valid[1] = v1; in_data[1] = d1;
        #1;
        for (int p = 0; p < 2; p++)
            chk($sformatf("in_ready[%0d]", p), in_ready[p], exp_ready(p, r));
        @(posedge clk);
        model_edge(0, v0, d0, r);
        model_edge(1, v1, d1, r);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("ser_out[%0d]", p),    ser_out[p],    exp_ser(p));
            chk($sformatf("ser_valid[%0d]", p),  ser_valid[p],  m_active[p]);
            chk($sformatf("busy[%0d]", p),       busy[p],       m_active[p]);
            chk($sformatf("bit_strobe[%0d]", p), bit_strobe[p], m_active[p] && (m_k[p] % pdiv(p) == 0));
            chk($sformatf("done[%0d]", p),       done[p],       m_done[p]);
        end
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    typedef struct {
        int         p;
        logic [7:0] data;
        logic [7:0] seq;   // seq[7] is the first bit on the line
    } vec_t;

    vec_t tbl [8];

    initial begin
        int   p, nb, ns, run, ones;
        bit   inrun, sent2;
        logic rdy, v0, v1, r;
        logic [7:0] d0, d1;

        tbl[0] = '{0, 8'h81, 8'b1000_0001};
        tbl[1] = '{0, 8'h0F, 8'b0000_1111};
        tbl[2] = '{0, 8'hA5, 8'b1010_0101};
        tbl[3] = '{0, 8'h01, 8'b0000_0001};
        tbl[4] = '{1, 8'h0F, 8'b1111_0000};
        tbl[5] = '{1, 8'hC3, 8'b1100_0011};
        tbl[6] = '{1, 8'hA5, 8'b1010_0101};
        tbl[7] = '{1, 8'h01, 8'b1000_0000};

        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_word[i] = '0; m_k[i] = 0;
            m_hf[i] = 1'b0; m_hold[i] = '0; m_done[i] = 1'b0;
        end

        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("reset_ser_out_a", ser_out[0], 1'b0);
        chk("reset_ser_out_b", ser_out[1], 1'b1);
        idle();

        for (int i = 0; i < 8; i++) begin
            p = tbl[i].p;
            nb = 0;
            ns = 0;
            if (p == 0) step(1'b1, tbl[i].data, 1'b0, 8'h00, 1'b0);
            else        step(1'b0, 8'h00, 1'b1, tbl[i].data, 1'b0);
            for (int k = 0; k < W * pdiv(p); k++) begin
                chk($sformatf("tbl%0d_bit%0d", i, k), ser_out[p], tbl[i].seq[7 - k / pdiv(p)]);
                if (busy[p]) nb++;
                if (bit_strobe[p]) ns++;
                idle();
            end
            chk_int($sformatf("tbl%0d_busy_cycles", i), nb, W * pdiv(p));
            chk_int($sformatf("tbl%0d_strobes", i), ns, W);
            chk($sformatf("tbl%0d_done", i), done[p], 1'b1);
            chk($sformatf("tbl%0d_gap_valid", i), ser_valid[p], 1'b0);
            idle();
            chk($sformatf("tbl%0d_done_single", i), done[p], 1'b0);
        end

        // in_valid held high with 0x55 then 0xAA
        step(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
        sent2 = 1'b0; run = 0; ones = 0; inrun = 1'b1;
        for (int k = 0; k < 17; k++) begin
            if (ser_valid[0]) ones++;
            if (inrun && ser_valid[0]) run++;
            else inrun = 1'b0;
            if (k == 0) chk("b2b_ready_in_shift", in_ready[0], PRE);
            if (k == 8) begin
                chk("b2b_gap_valid", ser_valid[0], PRE);
                chk("b2b_gap_ser_out", ser_out[0], PRE);
                chk("b2b_gap_done", done[0], 1'b1);
            end
            rdy = exp_ready(0, 1'b0);
            step(!sent2, 8'hAA, 1'b0, 8'h00, 1'b0);
            if (!sent2 && rdy) sent2 = 1'b1;
        end
        chk_int("b2b_first_run", run, PRE ? 16 : 8);
        chk_int("b2b_valid_cycles", ones, 16);
        idle();
        idle();

        // reset in cycle 4 of a word
        step(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
        idle();
        idle();
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("rst_ser_out", ser_out[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        idle();
        chk("rst_ready_after", in_ready[0], 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("rst_no_done", done[0], 1'b0);
            idle();
        end
        step(1'b1, 8'h96, 1'b0, 8'h00, 1'b0);
        chk("rst_next_bit0", ser_out[0], 1'b1);
        idle();
        chk("rst_next_bit1", ser_out[0], 1'b0);
        for (int k = 0; k < 9; k++) idle();

        // idle-high line with no traffic
        for (int k = 0; k < 20; k++) begin
            chk("idle_level_b", ser_out[1], 1'b1);
            chk("idle_valid_b", ser_valid[1], 1'b0);
            idle();
        end

        // randomized traffic and occasional resets
        for (int k = 0; k < 600; k++) begin
            v0 = ($urandom_range(0, 3) == 0);
            v1 = ($urandom_range(0, 3) == 0);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            r  = ($urandom_range(0, 79) == 0);
            step(v0, d0, v1, d1, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order, programmable bit period and idle line level. It is the successor to the team's fixed 8-bit load/shift register. It sits between word-producing logic (score/sprite/command generators) and any bit-serial sink (LED drivers, display shift chains, UART-style links), and reports framing through strobe, busy and done outputs.

## Interface
- DATA_WIDTH, 8: bits per word; must be ≥ 2.
- MSB_FIRST, 1: 1 shifts bit DATA_WIDTH-1 first; 0 shifts bit 0 first.
- DIV, 1: clock cycles per serial bit; must be ≥ 1.
- IDLE_LEVEL, 0: ser_out value when no word is being shifted.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data holds a word to send.
- in_data  in  DATA_WIDTH  parallel word.
- in_ready  out  1  a word is accepted on any edge where in_valid && in_ready.
- ser_out  out  1  serial data, registered.
- ser_valid  out  1  ser_out carries a data bit.
- bit_strobe  out  1  one-cycle pulse in the first cycle of every bit.
- busy  out  1  a word is being shifted.
- done  out  1  one-cycle pulse after the last bit of each word.

## Operation
- FSM states are IDLE and SHIFT.
- Counters:
  - div_cnt runs 0..DIV-1 and has width max(1,$clog2(DIV)).
  - bit_cnt runs 0..DATA_WIDTH-1 and has width $clog2(DATA_WIDTH).
- IDLE:
  - in_ready = 1 and ser_out = IDLE_LEVEL.
  - On accept: the shifter loads in_data, bit_cnt = 0, div_cnt = 0, and the FSM moves to SHIFT.
- SHIFT:
  - ser_out presents the current bit (MSB or LSB of the shifter, per MSB_FIRST).
  - div_cnt increments every cycle.
  - When div_cnt = DIV-1, div_cnt wraps to 0 and the shifter moves one position: left for MSB_FIRST, right otherwise, with zero fill.
  - On that same edge, if bit_cnt = DATA_WIDTH-1, the word ends: done is set for one cycle and the FSM returns to IDLE, or reloads as described under Configuration. Otherwise bit_cnt increments.
- Handshake:
  - in_valid may arrive in any state and is ignored while in_ready = 0.
  - in_data is sampled only on the accept edge.
- in_ready is combinational from state and buffer status, and is forced to 0 while rst = 1.
- Reset mid-word aborts the word:
  - The shifter, buffer and counters clear.
  - done is not pulsed.
  - ser_out returns to IDLE_LEVEL on the reset edge.

## Timing
- Reset values:
  - ser_out = IDLE_LEVEL.
  - ser_valid, bit_strobe, busy and done = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after.
- Latency:
  - The first data bit appears on ser_out in the cycle after the accept edge.
  - ser_valid, busy and bit_strobe assert in that same cycle.
- Each bit is held exactly DIV cycles, so a word occupies DATA_WIDTH × DIV cycles.
- bit_strobe pulses DATA_WIDTH times per word, at DIV-cycle spacing.
- done is high in the single cycle immediately after the last bit period.
- Without the holding buffer, at most one word is in flight. Back-to-back words therefore have exactly one gap cycle, in which ser_valid = 0, ser_out = IDLE_LEVEL and done = 1.

## Configuration
- Macro: PISO_SERIALIZER_PRELOAD_EN.
- Defined:
  - Adds a one-word holding buffer.
  - in_ready = !hold_full, so it is also 1 during SHIFT when the buffer is empty.
  - At the end of a word, if hold_full, the shifter loads from the buffer on the same edge and the FSM stays in SHIFT. The words run gapless: ser_valid stays 1, and done coincides with the first bit of the next word.
  - A simultaneous accept and buffer drain are legal:
    - The buffered word goes to the shifter.
    - The new word goes to the buffer.
    - hold_full stays 1.
  - An accept in IDLE with an empty buffer bypasses the buffer and loads the shifter directly.
- Undefined: no buffer; behaviour is exactly as stated above.

## Structure
- Package piso_serializer_pkg holds:
  - the FSM state enum (IDLE, SHIFT);
  - a function computing the counter widths.
- Sub-module bit_timer (parameter DIV) contains div_cnt. It emits:
  - tick, asserted when div_cnt = DIV-1;
  - first, asserted when div_cnt = 0.
- bit_timer takes an enable and synchronous clear from the FSM.
- The parent holds the FSM, shifter, bit_cnt, holding buffer and output registers.

## Test plan
- DATA_WIDTH=8, DIV=1, MSB_FIRST=1, accept 0x81:
  - ser_out = 1,0,0,0,0,0,0,1 over 8 cycles.
  - busy is high for 8 cycles.
  - done pulses at cycle 9 after the accept.
- MSB_FIRST=0, accept 0x0F: ser_out = 1,1,1,1,0,0,0,0.
- DIV=3, accept 0xC3:
  - Each bit is held 3 cycles, for 24 cycles total.
  - bit_strobe gives 8 pulses at 3-cycle spacing.
  - A single done pulse follows.
- in_valid held high with 0x55 then 0xAA:
  - Without PRELOAD_EN: one IDLE_LEVEL gap cycle between the words, and in_ready is 0 during SHIFT.
  - With PRELOAD_EN: 16 consecutive ser_valid cycles and no gap.
- rst asserted in cycle 4 of a word:
  - The next cycle shows ser_out = IDLE_LEVEL and busy = 0.
  - No done pulse.
  - in_ready = 1 after rst falls.
  - The next word shifts correctly from bit 0.
- With IDLE_LEVEL=1 and no traffic, ser_out stays 1 and ser_valid stays 0 indefinitely.
